// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction cache and its refill engine.
package icache_pkg;

    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned BLOCK_WIDTH    = 5;
    localparam int unsigned WORDS_PER_LINE = 1 << BLOCK_WIDTH;
    localparam int unsigned LINE_BITS      = WORDS_PER_LINE * DATA_WIDTH;
    localparam int unsigned OFFSET_LSB     = 2;
    localparam int unsigned LINE_LSB       = BLOCK_WIDTH + OFFSET_LSB;

    typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} refill_state_t;

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
    endfunction

    function automatic logic [BLOCK_WIDTH-1:0] word_offset(input logic [ADDR_WIDTH-1:0] addr);
        return addr[LINE_LSB-1:OFFSET_LSB];
    endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Miss, memory-burst and line-write signals between the refill engine and its neighbours.
interface icache_refill_if;
    import icache_pkg::*;

    logic                  miss_req;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic                  flush;
    logic                  refill_busy;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  crit_valid;
    logic [DATA_WIDTH-1:0] crit_data;
    logic                  line_we;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [LINE_BITS-1:0]  line_data;
    logic                  refill_done;

    modport master (
        input  miss_req, miss_addr, flush, mem_ack, mem_rvalid, mem_rdata,
        output refill_busy, mem_req, mem_addr, crit_valid, crit_data,
               line_we, line_addr, line_data, refill_done
    );

    modport slave (
        output miss_req, miss_addr, flush, mem_ack, mem_rvalid, mem_rdata,
        input  refill_busy, mem_req, mem_addr, crit_valid, crit_data,
               line_we, line_addr, line_data, refill_done
    );

endinterface

// File: rtl/icache_line_buf.sv
// One cache line of word registers: indexed single-word write, whole-line read.
module icache_line_buf
    import icache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [BLOCK_WIDTH-1:0] idx,
    input  logic [DATA_WIDTH-1:0]  wdata,
    output logic [LINE_BITS-1:0]   line
);

    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] words;

    always_ff @(posedge clk) begin
        if (rst) begin
            words <= '0;
        end else if (we) begin
            words[idx] <= wdata;
        end
    end

    // Packed word order puts word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
    assign line = words;

endmodule

// File: rtl/icache_refill.sv
// I-cache miss refill engine: one burst read per miss, critical-word forward, full-line write.
module icache_refill
    import icache_pkg::*;
(
    input logic             clk,
    input logic             rst,
    icache_refill_if.master bus
);

    localparam logic [BLOCK_WIDTH-1:0] LAST_BEAT = BLOCK_WIDTH'(WORDS_PER_LINE - 1);

    refill_state_t         state;
    logic [BLOCK_WIDTH-1:0] beat_cnt;
    logic [BLOCK_WIDTH-1:0] crit_off;
    logic                  flush_pending;
    logic [ADDR_WIDTH-1:0] line_addr_q;
    logic                  mem_req_q;
    logic                  crit_valid_q;
    logic [DATA_WIDTH-1:0] crit_data_q;
    logic                  line_we_q;
    logic                  refill_done_q;
    logic [LINE_BITS-1:0]  buf_line;

    logic beat_we;
    logic drop;

    assign beat_we = (state == FILL) && bus.mem_rvalid;
    // A flush arriving on the same cycle as a beat already counts against that beat.
    assign drop    = flush_pending || bus.flush;

    icache_line_buf u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (beat_we),
        .idx   (beat_cnt),
        .wdata (bus.mem_rdata),
        .line  (buf_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            crit_off      <= '0;
            flush_pending <= 1'b0;
            line_addr_q   <= '0;
            mem_req_q     <= 1'b0;
            crit_valid_q  <= 1'b0;
            crit_data_q   <= '0;
            line_we_q     <= 1'b0;
            refill_done_q <= 1'b0;
        end else begin
            crit_valid_q  <= 1'b0;
            line_we_q     <= 1'b0;
            refill_done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.miss_req) begin
                        line_addr_q <= line_align(bus.miss_addr);
                        crit_off    <= word_offset(bus.miss_addr);
                        mem_req_q   <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bus.flush) flush_pending <= 1'b1;
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (bus.flush) flush_pending <= 1'b1;
                    if (bus.mem_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == crit_off && !drop) begin
                            crit_valid_q <= 1'b1;
                            crit_data_q  <= bus.mem_rdata;
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            line_we_q     <= !drop;
                            refill_done_q <= 1'b1;
                            state         <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    flush_pending <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.refill_busy = (state != IDLE);
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = line_addr_q;
    assign bus.crit_valid  = crit_valid_q;
    assign bus.crit_data   = crit_data_q;
    assign bus.line_we     = line_we_q;
    assign bus.line_addr   = line_addr_q;
    assign bus.line_data   = buf_line;
    assign bus.refill_done = refill_done_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: table of refill scenarios plus reset and back-to-back sequences.
module tb_icache_refill;
    import icache_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          ack_delay;
        int          gap;
        int          flush_at;
        logic [31:0] base;
        logic [31:0] exp_mem_addr;
        bit          exp_crit;
        int          exp_crit_cyc;
        logic [31:0] exp_crit_data;
        bit          exp_we;
        int          exp_done_cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    icache_refill_if bus ();

    icache_refill dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc, crit_cnt, crit_cyc, we_cnt, done_cnt, done_cyc, idle_cnt, req_drop;
    logic [31:0] crit_dat;
    rec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_line(input string name, input logic [LINE_BITS-1:0] act,
                              input logic [LINE_BITS-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_mon();
        cyc = 0; crit_cnt = 0; crit_cyc = 0; we_cnt = 0; done_cnt = 0; done_cyc = 0;
        idle_cnt = 0; req_drop = 0; crit_dat = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.crit_valid)   begin crit_cnt++; crit_cyc = cyc; crit_dat = bus.crit_data; end
        if (bus.line_we)      we_cnt++;
        if (bus.refill_done)  begin done_cnt++; done_cyc = cyc; end
        if (!bus.refill_busy) idle_cnt++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      64'(bus.refill_busy), 64'd0);
        check({tag, "_mem_req"},   64'(bus.mem_req),     64'd0);
        check({tag, "_mem_addr"},  64'(bus.mem_addr),    64'd0);
        check({tag, "_crit_v"},    64'(bus.crit_valid),  64'd0);
        check({tag, "_crit_d"},    64'(bus.crit_data),   64'd0);
        check({tag, "_line_we"},   64'(bus.line_we),     64'd0);
        check({tag, "_line_addr"}, 64'(bus.line_addr),   64'd0);
        check({tag, "_done"},      64'(bus.refill_done), 64'd0);
        check_line({tag, "_line_data"}, bus.line_data, '0);
    endtask

    task automatic send_beats(input logic [31:0] base, input int gap, input int flush_at);
        for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
            for (int g = 0; g < gap; g++) begin
                bus.mem_rvalid = 1'b0;
                tick();
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = base + 32'(k);
            bus.flush      = (k == flush_at);
            tick();
            bus.mem_rvalid = 1'b0;
            bus.flush      = 1'b0;
        end
    endtask

    function automatic logic [LINE_BITS-1:0] model_line(input logic [31:0] base);
        logic [LINE_BITS-1:0] l;
        for (int k = 0; k < int'(WORDS_PER_LINE); k++) l[k*DATA_WIDTH +: DATA_WIDTH] = base + 32'(k);
        return l;
    endfunction

    task automatic run_refill(input string tag, input rec_t r);
        clear_mon();
        bus.miss_req  = 1'b1;
        bus.miss_addr = r.addr;
        tick();
        check({tag, "_mem_req"},  64'(bus.mem_req),  64'd1);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(r.exp_mem_addr));
        for (int d = 0; d < r.ack_delay; d++) begin
            tick();
            if (!bus.mem_req) req_drop++;
        end
        if (r.ack_delay > 0) check({tag, "_req_held"}, 64'(req_drop), 64'd0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check({tag, "_req_drop"}, 64'(bus.mem_req), 64'd0);
        send_beats(r.base, r.gap, r.flush_at);
        check({tag, "_done_cnt"},  64'(done_cnt),      64'd1);
        check({tag, "_done_cyc"},  64'(done_cyc),      64'(r.exp_done_cyc));
        check({tag, "_line_we"},   64'(bus.line_we),   64'(r.exp_we));
        check({tag, "_we_cnt"},    64'(we_cnt),        64'(r.exp_we));
        check({tag, "_crit_cnt"},  64'(crit_cnt),      64'(r.exp_crit));
        check({tag, "_busy_low"},  64'(idle_cnt),      64'd0);
        check({tag, "_line_addr"}, 64'(bus.line_addr), 64'(r.exp_mem_addr));
        if (r.exp_crit) begin
            check({tag, "_crit_cyc"},  64'(crit_cyc), 64'(r.exp_crit_cyc));
            check({tag, "_crit_data"}, 64'(crit_dat), 64'(r.exp_crit_data));
        end
        if (r.exp_we) check_line({tag, "_line_data"}, bus.line_data, model_line(r.base));
        bus.miss_req = 1'b0;
        tick();
        check({tag, "_idle_after"}, 64'(bus.refill_busy), 64'd0);
        check({tag, "_done_pulse"}, 64'(bus.refill_done), 64'd0);
    endtask

    initial begin
        bus.miss_req = 1'b0; bus.miss_addr = '0; bus.flush = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        //        addr          dly gap flush base          mem_addr      crit cyc data      we done
        vecs[0] = '{32'h0000_1234, 0, 0, -1, 32'hA000_0000, 32'h0000_1200, 1, 16, 32'hA000_000D, 1, 34};
        vecs[1] = '{32'h0000_2004, 5, 1, -1, 32'hB000_0000, 32'h0000_2000, 1, 11, 32'hB000_0001, 1, 71};
        vecs[2] = '{32'h0000_3030, 0, 0, 11, 32'hC000_0000, 32'h0000_3000, 0,  0, 32'h0,        0, 34};
        vecs[3] = '{32'h0000_3024, 0, 0, 11, 32'hD000_0000, 32'h0000_3000, 1, 12, 32'hD000_0009, 0, 34};
        vecs[4] = '{32'h0000_402C, 0, 0, 11, 32'h2000_0000, 32'h0000_4000, 0,  0, 32'h0,        0, 34};
        vecs[5] = '{32'h0000_5000, 0, 0, -1, 32'hE000_0000, 32'h0000_5000, 1,  3, 32'hE000_0000, 1, 34};
        vecs[6] = '{32'h0000_607C, 0, 0, -1, 32'hF000_0000, 32'h0000_6000, 1, 34, 32'hF000_001F, 1, 34};
        vecs[7] = '{32'h8765_43C8, 0, 0, -1, 32'h1111_0000, 32'h8765_4380, 1, 21, 32'h1111_0012, 1, 34};

        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_refill($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of a burst, then stray beats while idle.
        clear_mon();
        bus.miss_req = 1'b1; bus.miss_addr = 32'h0000_7010;
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_0000 + 32'(k);
            tick();
        end
        check("rst_pre_crit", 64'(crit_cnt), 64'd1);
        bus.miss_req = 1'b0;
        rst = 1'b1;
        bus.mem_rdata = 32'h5555_0008;
        tick();
        rst = 1'b0;
        check_all_zero("rst_mid");
        clear_mon();
        for (int k = 9; k < 17; k++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_0000 + 32'(k);
            tick();
        end
        bus.mem_rvalid = 1'b0;
        check("stray_we",   64'(we_cnt),   64'd0);
        check("stray_done", 64'(done_cnt), 64'd0);
        check("stray_crit", 64'(crit_cnt), 64'd0);
        check("stray_busy", 64'(idle_cnt), 64'd8);
        check_line("stray_line", bus.line_data, '0);
        run_refill("post_rst", vecs[0]);

        // Back-to-back misses: address changes during the WRITE cycle.
        clear_mon();
        bus.miss_req = 1'b1; bus.miss_addr = 32'h0000_9000;
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        send_beats(32'h3000_0000, 0, -1);
        check("b2b_done_cyc", 64'(done_cyc), 64'd34);
        bus.miss_addr = 32'h0000_A0C4;
        tick();
        check("b2b_gap_req",  64'(bus.mem_req),     64'd0);
        check("b2b_gap_busy", 64'(bus.refill_busy), 64'd0);
        tick();
        check("b2b_req2_cyc",  64'(cyc),          64'd36);
        check("b2b_req2",      64'(bus.mem_req),  64'd1);
        check("b2b_req2_addr", 64'(bus.mem_addr), 64'h0000_A080);
        crit_cnt = 0;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        send_beats(32'h4000_0000, 0, -1);
        check("b2b2_line_we",   64'(bus.line_we),   64'd1);
        check("b2b2_line_addr", 64'(bus.line_addr), 64'h0000_A080);
        check("b2b2_crit_cnt",  64'(crit_cnt),      64'd1);
        check("b2b2_crit_data", 64'(crit_dat),      64'h4000_0011);
        check_line("b2b2_line_data", bus.line_data, model_line(32'h4000_0000));
        bus.miss_req = 1'b0;
        tick();
        check("b2b2_idle", 64'(bus.refill_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
Miss-handling refill engine that sits directly upstream of the instruction cache data array.
- On an instruction-cache miss it issues one line-aligned burst read to memory and collects WORDS_PER_LINE beats into a line buffer.
- It then writes the complete line into the cache in one cycle.
- It forwards the critical (missed) word to fetch as soon as that beat arrives.
- A flush during a refill drains the burst and suppresses the cache write.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, memory beat / instruction word width
BLOCK_WIDTH, 5, log2 of words per line; WORDS_PER_LINE = 32, LINE_BITS = WORDS_PER_LINE*DATA_WIDTH = 1024

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
miss_req  in  1  cache lookup missed; held by cache until refill_done
miss_addr  in  ADDR_WIDTH  byte address of missed instruction
flush  in  1  one-cycle pulse; discard current refill
refill_busy  out  1  engine not in IDLE
mem_req  out  1  burst read request, held until mem_ack
mem_addr  out  ADDR_WIDTH  line-aligned address (low BLOCK_WIDTH+2 bits zero)
mem_ack  in  1  memory accepted request this cycle
mem_rvalid  in  1  read beat valid, beats in ascending word order
mem_rdata  in  DATA_WIDTH  read beat data
crit_valid  out  1  one-cycle pulse: critical word available
crit_data  out  DATA_WIDTH  critical word
line_we  out  1  one-cycle cache line write strobe
line_addr  out  ADDR_WIDTH  line-aligned address for line_we
line_data  out  LINE_BITS  assembled line, word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
refill_done  out  1  one-cycle pulse: refill finished (written or discarded)

Behaviour:
- Reset (rst=1 at posedge): state IDLE, beat_cnt=0, flush_pending=0; all outputs 0, including line_data, line_addr, mem_addr and crit_data. rst mid-burst aborts immediately; later beats are ignored in IDLE.
- States: IDLE, REQ, FILL, WRITE.
- IDLE: if miss_req, latch line_addr = miss_addr with low BLOCK_WIDTH+2 bits cleared, and crit_off = miss_addr[BLOCK_WIDTH+1:2]; go to REQ. miss_req is sampled only in IDLE.
- REQ: mem_req=1, mem_addr=line_addr. Request is never withdrawn, even on flush. On mem_ack, go to FILL with beat_cnt=0. mem_req is 0 from the next cycle.
- FILL: on each mem_rvalid, store mem_rdata into word beat_cnt and increment beat_cnt. On the beat where beat_cnt==WORDS_PER_LINE-1, go to WRITE. Cycles without mem_rvalid hold state.
- Critical word: on the beat where beat_cnt==crit_off and flush_pending==0 (and flush not asserted that cycle), the next cycle has crit_valid=1 and crit_data = that beat.
- WRITE (one cycle): refill_done=1; line_we = ~flush_pending; line_data = buffer; then go to IDLE and clear flush_pending.
- flush in REQ or FILL sets flush_pending. flush in IDLE or WRITE has no effect.
- mem_rvalid outside FILL is ignored. mem_ack outside REQ is ignored.
- Latency (zero-wait memory): miss_req seen at cycle 0 → mem_req at cycle 1, acked at cycle 1 → beats at cycles 2..33 → line_we/refill_done at cycle 34 → IDLE at cycle 35. Earliest next miss is accepted at cycle 35.
- crit_valid fires at most once per refill. It never fires in the WRITE cycle's refill if flushed.

Decomposition:
- Package icache_pkg: ADDR_WIDTH, DATA_WIDTH, BLOCK_WIDTH, WORDS_PER_LINE, LINE_BITS, OFFSET_LSB=2, refill_state_t enum {IDLE, REQ, FILL, WRITE}. The cache array shares these constants.
- One sub-module, icache_line_buf: a WORDS_PER_LINE×DATA_WIDTH register buffer with indexed word write (we, idx, wdata) and full-line read.
- FSM, counter and critical-word logic stay in icache_refill.

Test Plan:
- Basic refill: miss_addr=0x0000_1234, mem_ack immediate, beats k=0..31 carry data 0xA000_0000+k → mem_addr=0x0000_1200; crit_valid at cycle 16 (offset 13 → beat at cycle 15); crit_data=0xA000_000D; line_we at cycle 34; line_data word 31 = 0xA000_001F.
- Stalled memory: mem_ack delayed 5 cycles, then one idle cycle between every beat → mem_req held through the wait; a single line_we after beat 31; refill_busy=1 throughout.
- Flush mid-FILL: flush pulse after beat 10 → remaining beats consumed; refill_done=1 with line_we=0; no crit_valid if crit_off>10; IDLE afterwards.
- Reset mid-FILL: rst after beat 7, then stray mem_rvalid beats → all outputs 0 and no line_we. A new miss then refills correctly.
- Back-to-back misses: miss_req held high with the address changed in the WRITE cycle → second mem_req at cycle 36, carrying the new aligned address.
- Offset edges: crit_off=0 and crit_off=31 → crit_valid the cycle after beat 0 and after beat 31 respectively. For offset 31, crit_valid coincides with WRITE.
